btn_led_effect: RTL

Parametrised successor to the single-button LED counter. Two debounced push-buttons drive a WIDTH-bit LED pattern generator: btn_step advances the current pattern, btn_mode cycles through four effects (count up, count down, rotate, ping-pong). Sits between the board buttons and the LED pins; fully synchronous to one system clock, with no derived clocks.

---
 rtl/btn_led_effect.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/btn_led_effect.sv
// btn_led_effect: two debounced push-buttons drive a WIDTH-bit LED pattern.
//   btn_step advances the pattern according to the current effect.
//   btn_mode cycles the effect: 0 count up, 1 count down, 2 rotate, 3 ping-pong.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   btn_step - raw step button (asynchronous, high = pressed)
//   btn_mode - raw mode button (asynchronous, high = pressed)
//   q        - registered LED pattern, WIDTH bits
//   mode     - registered current effect, 2 bits

// btn_led_effect_deb: 2-FF synchroniser plus debouncer for one button.
//   i_pin   - raw asynchronous button level
//   o_press - one-cycle strobe, high in the cycle whose edge raises the
//             debounced level from 0 to 1
module btn_led_effect_deb #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff  = r_sync2 ^ r_deb;
  assign w_done  = w_diff && (r_cnt == CNT_MAX);
  // The debounced level flips on this edge; only a rising flip is a press.
  assign o_press = w_done & r_sync2;

  // Synchroniser, debounce counter and accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      if (!w_diff) begin
        // Any agreement (including a bounce back) restarts the count.
        r_cnt <= {CW{1'b0}};
      end else if (w_done) begin
        r_deb <= r_sync2;
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1'b1);
      end
    end
  end

endmodule

module btn_led_effect #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_mode,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode
);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [1:0]       MODE_UP   = 2'd0;
  localparam logic [1:0]       MODE_DOWN = 2'd1;
  localparam logic [1:0]       MODE_ROT  = 2'd2;
  localparam logic [1:0]       MODE_PING = 2'd3;
  localparam logic [WIDTH-1:0] Q_ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Q_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_step_press;
  logic             w_mode_press;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_mode;
  dir_t             r_dir;
  logic [WIDTH-1:0] w_q_nxt;
  logic [1:0]       w_mode_nxt;
  dir_t             w_dir_nxt;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;

  btn_led_effect_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (btn_step),
    .o_press (w_step_press)
  );

  btn_led_effect_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .reset   (reset),
    .i_pin   (btn_mode),
    .o_press (w_mode_press)
  );

  assign w_shl = {r_q[WIDTH-2:0], 1'b0};
  assign w_shr = {1'b0, r_q[WIDTH-1:1]};

  // Next pattern / effect / direction; a mode press overrides a step press.
  always_comb begin
    w_q_nxt    = r_q;
    w_mode_nxt = r_mode;
    w_dir_nxt  = r_dir;
    if (w_mode_press) begin
      w_mode_nxt = r_mode + 2'd1;
      w_dir_nxt  = DIR_LEFT;
      if ((r_mode + 2'd1) >= MODE_ROT) begin
        w_q_nxt = Q_ONE;
      end else begin
        w_q_nxt = Q_ZERO;
      end
    end else if (w_step_press) begin
      case (r_mode)
        MODE_UP:   w_q_nxt = r_q + Q_ONE;
        MODE_DOWN: w_q_nxt = r_q - Q_ONE;
        MODE_ROT:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_PING: begin
          if (r_dir == DIR_LEFT) begin
            w_q_nxt = w_shl;
            if (w_shl[WIDTH-1]) begin
              w_dir_nxt = DIR_RIGHT;
            end else begin
              w_dir_nxt = DIR_LEFT;
            end
          end else begin
            w_q_nxt = w_shr;
            if (w_shr[0]) begin
              w_dir_nxt = DIR_LEFT;
            end else begin
              w_dir_nxt = DIR_RIGHT;
            end
          end
        end
        default:   w_q_nxt = r_q;
      endcase
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Pattern, effect and bounce-direction state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= Q_ZERO;
      r_mode <= MODE_UP;
      r_dir  <= DIR_LEFT;
    end else begin
      r_q    <= w_q_nxt;
      r_mode <= w_mode_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  assign q    = r_q;
  assign mode = r_mode;

endmodule
